// File: rtl/alu_e_mem_unit.sv
// alu_e_mem_unit: combinational 16-bit ALU, the E extend/carry flip-flop and
// the 4096-word main memory of the basic-computer datapath.
module alu_e_mem_unit #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      AC,
  input  logic [WIDTH-1:0]      DR,
  input  logic [2:0]            OPSEL,
  input  logic                  LD_E,
  input  logic                  CMP_E,
  input  logic                  CLR_E,
  input  logic                  MEM_WE,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [WIDTH-1:0]      MEM_WDATA,
  output logic [WIDTH-1:0]      MEM_RDATA,
  output logic [WIDTH-1:0]      RESULT,
  output logic                  CO,
  output logic                  Z,
  output logic                  N,
  output logic                  OVF,
  output logic                  E
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_ADD  = 3'b001,
    OP_LDA  = 3'b010,
    OP_CMA  = 3'b011,
    OP_CIR  = 3'b100,
    OP_CIL  = 3'b101,
    OP_INC  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic             e_q;
  logic [1:0]       e_ctl;   // [1] op updates E, [0] value E would take
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   inc;
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  assign sum = {1'b0, AC} + {1'b0, DR};
  assign inc = {1'b0, AC} + {{WIDTH{1'b0}}, 1'b1};

  // ALU: result, carry/overflow and the E-update request for the current op
  always_comb begin
    RESULT = AC;
    CO     = 1'b0;
    OVF    = 1'b0;
    e_ctl  = 2'b00;
    case (op_e'(OPSEL))
      OP_AND:  RESULT = AC & DR;
      OP_ADD: begin
        RESULT = sum[WIDTH-1:0];
        CO     = sum[WIDTH];
        OVF    = (AC[WIDTH-1] == DR[WIDTH-1]) && (sum[WIDTH-1] != AC[WIDTH-1]);
        e_ctl  = {1'b1, sum[WIDTH]};
      end
      OP_LDA:  RESULT = DR;
      OP_CMA:  RESULT = ~AC;
      OP_CIR: begin
        RESULT = {e_q, AC[WIDTH-1:1]};
        CO     = AC[0];
        e_ctl  = {1'b1, AC[0]};
      end
      OP_CIL: begin
        RESULT = {AC[WIDTH-2:0], e_q};
        CO     = AC[WIDTH-1];
        e_ctl  = {1'b1, AC[WIDTH-1]};
      end
      OP_INC: begin
        RESULT = inc[WIDTH-1:0];
        CO     = inc[WIDTH];
        // only the largest positive value overflows on +1
        OVF    = (AC == {1'b0, {(WIDTH-1){1'b1}}});
      end
      default: RESULT = AC;
    endcase
  end

  assign Z = (RESULT == '0);
  assign N = RESULT[WIDTH-1];

  // E flip-flop: reset > clear > ALU load > complement > hold.
  // LD_E with an op that doesn't touch E holds, and also masks CMP_E.
  always_ff @(posedge clk) begin
    if (RST)
      e_q <= 1'b0;
    else if (CLR_E)
      e_q <= 1'b0;
    else if (LD_E) begin
      if (e_ctl[1])
        e_q <= e_ctl[0];
    end else if (CMP_E)
      e_q <= ~e_q;
  end

  assign E = e_q;

  // Memory write port; contents survive RST
  always_ff @(posedge clk) begin
    if (MEM_WE)
      mem[MEM_ADDR] <= MEM_WDATA;
  end

  assign MEM_RDATA = mem[MEM_ADDR];

endmodule

// File: tb/tb_alu_e_mem_unit.sv
// Scoreboard bench for alu_e_mem_unit: the stimulus process pushes expected
// responses from an arithmetic reference model; a negedge monitor pops them.
module tb_alu_e_mem_unit;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] AC = '0, DR = '0;
  logic [2:0]  OPSEL = '0;
  logic        LD_E = 1'b0, CMP_E = 1'b0, CLR_E = 1'b0, MEM_WE = 1'b0;
  logic [11:0] MEM_ADDR = '0;
  logic [15:0] MEM_WDATA = '0;
  logic [15:0] MEM_RDATA, RESULT;
  logic        CO, Z, N, OVF, E;

  alu_e_mem_unit #(.WIDTH(16), .ADDR_WIDTH(12)) dut (
    .clk(clk), .RST(RST), .AC(AC), .DR(DR), .OPSEL(OPSEL),
    .LD_E(LD_E), .CMP_E(CMP_E), .CLR_E(CLR_E), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .RESULT(RESULT), .CO(CO), .Z(Z), .N(N), .OVF(OVF), .E(E)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        co, z, n, ovf;
    logic        chk_e, e;
    logic [15:0] rd;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miss    = 0;
  logic        m_e;          // model E; x until first reset
  logic [15:0] m_mem [int];  // sparse model memory, absent == 0

  // Reference ALU from plain integer arithmetic on the op's meaning
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic e);
    exp_t x;
    int ua, ub, sa, sb, s;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    x = '0;
    case (op)
      3'd0: x.res = a & b;
      3'd1: begin
        s = ua + ub; x.res = 16'(s); x.co = (s > 65535);
        x.ovf = (sa + sb > 32767) || (sa + sb < -32768);
      end
      3'd2: x.res = b;
      3'd3: x.res = ~a;
      3'd4: begin x.res = 16'((int'(e) * 32768) + ua / 2); x.co = (ua % 2) == 1; end
      3'd5: begin x.res = 16'(ua * 2 + int'(e)); x.co = (ua >= 32768); end
      3'd6: begin s = ua + 1; x.res = 16'(s); x.co = (s > 65535); x.ovf = (sa + 1 > 32767); end
      default: x.res = a;
    endcase
    x.z = (x.res == 16'd0);
    x.n = (int'(x.res) >= 32768);
    return x;
  endfunction

  // Apply one cycle of stimulus, queue the expectation, then advance the model
  task automatic drive(input logic rst, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ld, input logic cmp,
                       input logic clr, input logic we, input logic [11:0] addr,
                       input logic [15:0] wd);
    exp_t x;
    RST = rst; OPSEL = op; AC = a; DR = b; LD_E = ld; CMP_E = cmp; CLR_E = clr;
    MEM_WE = we; MEM_ADDR = addr; MEM_WDATA = wd;
    x = model(op, a, b, m_e);
    x.chk_e = (m_e !== 1'bx);
    x.e     = m_e;
    x.rd    = m_mem.exists(int'(addr)) ? m_mem[int'(addr)] : 16'h0;
    sb_q.push_back(x);
    @(posedge clk);
    if (rst)                       m_e = 1'b0;
    else if (clr)                  m_e = 1'b0;
    else if (ld) begin
      if (op == 3'd1)              m_e = (int'(a) + int'(b)) > 65535;
      else if (op == 3'd4)         m_e = a[0];
      else if (op == 3'd5)         m_e = a[15];
    end else if (cmp)              m_e = ~m_e;
    if (we) m_mem[int'(addr)] = wd;
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h (vector %0d)", nm, act, exp, vectors);
    end
  endtask

  // Monitor: outputs are combinational, so each cycle presents one response
  always @(negedge clk) begin
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      vectors++;
      chk("RESULT", RESULT, x.res);
      chk("CO", {15'd0, CO}, {15'd0, x.co});
      chk("Z", {15'd0, Z}, {15'd0, x.z});
      chk("N", {15'd0, N}, {15'd0, x.n});
      chk("OVF", {15'd0, OVF}, {15'd0, x.ovf});
      chk("MEM_RDATA", MEM_RDATA, x.rd);
      if (x.chk_e) chk("E", {15'd0, E}, {15'd0, x.e});
    end
  end

  initial begin
    logic [11:0] pool [4];
    logic [11:0] ad;
    m_e = 1'bx;
    pool = '{12'h000, 12'hFFF, 12'h123, 12'h5A5};
    @(posedge clk); #1;
    // reset, ADD carry into E
    drive(1, 3'd1, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd1, 16'hFFFF, 16'h0001, 1, 0, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd1, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 12'h000, 16'h0);
    // rotates through E
    drive(0, 3'd4, 16'h0002, 16'h0000, 1, 0, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd5, 16'h8000, 16'h0000, 1, 0, 0, 0, 12'h000, 16'h0);
    // logic ops and INC (INC must not move E)
    drive(0, 3'd0, 16'hF0F0, 16'h0FF0, 0, 0, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd3, 16'h00FF, 16'h0000, 0, 0, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd2, 16'h0000, 16'h1234, 0, 0, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd6, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd6, 16'h7FFF, 16'h0000, 0, 0, 0, 0, 12'h000, 16'h0);
    // E control priorities
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 1, 1, 0, 12'h000, 16'h0);
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 1, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 1, 1, 0, 12'h000, 16'h0);
    drive(0, 3'd0, 16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd0, 16'hFFFF, 16'hFFFF, 1, 1, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 0, 0, 0, 12'h000, 16'h0);
    // memory: writes, reads, reset leaves contents, unwritten reads zero
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 0, 0, 1, 12'h000, 16'hBEEF);
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 0, 0, 1, 12'hFFF, 16'hCAFE);
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 0, 0, 0, 12'h000, 16'h0);
    drive(1, 3'd7, 16'h0000, 16'h0000, 0, 0, 0, 0, 12'hFFF, 16'h0);
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 0, 0, 0, 12'h000, 16'h0);
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 0, 0, 0, 12'hFFF, 16'h0);
    drive(0, 3'd7, 16'h0000, 16'h0000, 0, 0, 0, 0, 12'h123, 16'h0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ad = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : 12'($urandom);
      drive(($urandom_range(0, 39) == 0), 3'($urandom), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), ad, 16'($urandom));
    end
    @(negedge clk); #1;
    if (sb_q.size() != 0) begin
      miss++;
      $display("FAIL drain: %0d responses left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
